// File: rtl/sdram_responder.sv
// sdram_responder: device-side SDR SDRAM model with backing array, CAS-latency read pipeline and protocol checks
module sdram_responder #(
  parameter int ROW_WIDTH = 13,
  parameter int COL_WIDTH = 9,
  parameter int MEM_AW = 12,
  parameter int T_RCD = 2,
  parameter int T_RP = 2,
  parameter int T_RC = 3,
  parameter int T_MRD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cke,
  input  logic                 cs,
  input  logic                 ras,
  input  logic                 cas,
  input  logic                 we,
  input  logic [1:0]           ba,
  input  logic [ROW_WIDTH-1:0] addr,
  input  logic [1:0]           dqm,
  input  logic                 wr_en,
  input  logic [15:0]          write_data,
  output logic [15:0]          read_data,
  output logic                 rd_valid,
  output logic                 init_done,
  output logic [ROW_WIDTH-1:0] mode_reg,
  output logic [7:0]           err
);
  typedef enum logic [1:0] {S_UNINIT, S_PRECHARGED, S_READY} state_t;
  localparam logic [3:0] L_RCD = 4'(T_RCD - 1);
  localparam logic [3:0] L_RP = 4'(T_RP - 1);
  localparam logic [3:0] L_RP_AP = 4'(T_RP);
  localparam logic [3:0] L_RC = 4'(T_RC - 1);
  localparam logic [3:0] L_MRD = 4'(T_MRD - 1);
  state_t r_state, w_state_nx;
  logic [3:0] r_act;
  logic [ROW_WIDTH-1:0] r_row [4];
  logic [3:0] r_rcd [4];
  logic [3:0] r_rp [4];
  logic [3:0] r_rc, r_mrd;
  logic r_rc_ref;
  logic [1:0] r_bll;
  logic r_cl3;
  logic [7:0] r_err, w_err;
  logic [2:0] r_b_left, r_b_k;
  logic [1:0] r_b_ba;
  logic [ROW_WIDTH-1:0] r_b_row;
  logic [COL_WIDTH-1:0] r_b_col;
  logic r_b_rd, r_b_ap;
  logic [15:0] r_mem [2**MEM_AW];
  logic r_p1_v, r_p2_v, r_rd_valid;
  logic [15:0] r_p1_d, r_p2_d, r_read_data;
  logic [ROW_WIDTH-1:0] r_mode;
  logic w_cmd, w_act, w_pre, w_wr, w_rd, w_mrs, w_ref, w_nn, w_a10, w_ready;
  logic w_act_ok, w_cmd_rw, w_any_rp, w_bl_ok, w_cl_ok;
  logic w_beat, w_last, w_brd, w_bap;
  logic [2:0] w_k, w_blm;
  logic [1:0] w_bba;
  logic [ROW_WIDTH-1:0] w_brow;
  logic [COL_WIDTH-1:0] w_col0, w_m, w_col;
  logic [MEM_AW-1:0] w_maddr;
  assign w_cmd = cke & ~cs;
  assign w_act = w_cmd && {ras, cas, we} == 3'b011;
  assign w_pre = w_cmd && {ras, cas, we} == 3'b010;
  assign w_wr = w_cmd && {ras, cas, we} == 3'b100;
  assign w_rd = w_cmd && {ras, cas, we} == 3'b101;
  assign w_mrs = w_cmd && {ras, cas, we} == 3'b000;
  assign w_ref = w_cmd && {ras, cas, we} == 3'b001;
  assign w_nn = w_act | w_pre | w_wr | w_rd | w_mrs | w_ref;
  assign w_a10 = addr[10];
  assign w_ready = r_state == S_READY;
  assign w_act_ok = w_act && w_ready && !r_act[ba];
  assign w_cmd_rw = (w_wr | w_rd) && w_ready && r_act[ba];
  assign w_any_rp = (r_rp[0] != 4'd0) | (r_rp[1] != 4'd0) | (r_rp[2] != 4'd0) | (r_rp[3] != 4'd0);
  assign w_bl_ok = !addr[2];
  assign w_cl_ok = addr[6:5] == 2'b01;
  // A new READ/WRITE is beat 0 this edge and truncates any running burst
  assign w_beat = w_cmd_rw || r_b_left != 3'd0;
  assign w_k = w_cmd_rw ? 3'd0 : r_b_k;
  assign w_blm = 3'((4'd1 << r_bll) - 4'd1);
  assign w_last = w_beat && w_k >= w_blm;
  assign w_brd = w_cmd_rw ? w_rd : r_b_rd;
  assign w_bap = w_cmd_rw ? w_a10 : r_b_ap;
  assign w_bba = w_cmd_rw ? ba : r_b_ba;
  assign w_brow = w_cmd_rw ? r_row[ba] : r_b_row;
  assign w_col0 = w_cmd_rw ? addr[COL_WIDTH-1:0] : r_b_col;
  assign w_m = COL_WIDTH'(w_blm);
  assign w_col = (w_col0 & ~w_m) | ((w_col0 + COL_WIDTH'(w_k)) & w_m);
  assign w_maddr = MEM_AW'({w_bba, w_brow, w_col});
  assign read_data = r_read_data;
  assign rd_valid = r_rd_valid;
  assign init_done = r_state == S_READY;
  assign mode_reg = r_mode;
  assign err = r_err;
  // Protocol violations detected by the command sampled this edge
  always_comb begin
    w_err = 8'd0;
    w_err[0] = (w_wr | w_rd) && w_ready && !r_act[ba];
    w_err[1] = w_act && w_ready && r_act[ba];
    w_err[2] = (w_wr | w_rd) && r_rcd[ba] != 4'd0;
    w_err[3] = (w_act && r_rp[ba] != 4'd0) || (w_ref && w_any_rp);
    w_err[4] = (w_act && r_rc != 4'd0) || (w_nn && (r_mrd != 4'd0 || (r_rc_ref && r_rc != 4'd0)));
    w_err[5] = (w_act | w_wr | w_rd) && !w_ready;
    w_err[6] = w_mrs && !(w_bl_ok && w_cl_ok);
    w_err[7] = (w_ref | w_mrs) && r_act != 4'd0;
  end
  // Init sequence: PRECHARGE-all then MODE_SET
  always_comb begin
    w_state_nx = (r_state == S_UNINIT && w_pre && w_a10) ? S_PRECHARGED :
                 (r_state == S_PRECHARGED && w_mrs) ? S_READY : r_state;
  end
  // Init state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_UNINIT;
    else r_state <= w_state_nx;
  // Bank open/idle state and timing counters; auto-precharge counts from the edge after the last beat
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_act <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        r_row[i] <= '0;
        r_rcd[i] <= 4'd0;
        r_rp[i] <= 4'd0;
      end
      r_rc <= 4'd0;
      r_rc_ref <= 1'b0;
      r_mrd <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_rcd[i] <= r_rcd[i] != 4'd0 ? r_rcd[i] - 4'd1 : 4'd0;
        r_rp[i] <= r_rp[i] != 4'd0 ? r_rp[i] - 4'd1 : 4'd0;
      end
      r_rc <= r_rc != 4'd0 ? r_rc - 4'd1 : 4'd0;
      r_mrd <= r_mrd != 4'd0 ? r_mrd - 4'd1 : 4'd0;
      if (w_act_ok) begin
        r_act[ba] <= 1'b1;
        r_row[ba] <= addr;
        r_rcd[ba] <= L_RCD;
      end
      if (w_act_ok || w_ref) begin
        r_rc <= L_RC;
        r_rc_ref <= w_ref;
      end
      if (w_mrs) r_mrd <= L_MRD;
      if (w_pre)
        for (int i = 0; i < 4; i++)
          if (w_a10 || ba == 2'(i)) begin
            r_act[i] <= 1'b0;
            r_rp[i] <= L_RP;
          end
      if (w_last && w_bap) begin
        r_act[w_bba] <= 1'b0;
        r_rp[w_bba] <= L_RP_AP;
      end
    end
  // Mode register; illegal BL/CL fields fall back to BL=1 / CL=2
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mode <= '0;
      r_bll <= 2'd0;
      r_cl3 <= 1'b0;
    end else if (w_mrs) begin
      r_mode <= addr;
      r_bll <= w_bl_ok ? addr[1:0] : 2'd0;
      r_cl3 <= w_cl_ok & addr[4];
    end
  // Sticky error flags
  always_ff @(posedge clk or posedge rst)
    if (rst) r_err <= 8'd0;
    else r_err <= r_err | w_err;
  // Burst engine: remembers the burst origin and which beat comes next
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_b_left <= 3'd0;
      r_b_k <= 3'd0;
      r_b_ba <= 2'd0;
      r_b_row <= '0;
      r_b_col <= '0;
      r_b_rd <= 1'b0;
      r_b_ap <= 1'b0;
    end else begin
      if (w_beat) begin
        r_b_left <= w_last ? 3'd0 : w_blm - w_k;
        r_b_k <= w_k + 3'd1;
      end
      if (w_cmd_rw) begin
        r_b_ba <= ba;
        r_b_row <= r_row[ba];
        r_b_col <= addr[COL_WIDTH-1:0];
        r_b_rd <= w_rd;
        r_b_ap <= w_a10;
      end
    end
  // Backing array with byte masks; also the first read pipeline stage (not reset)
  always_ff @(posedge clk) begin
    if (w_beat && !w_brd && wr_en && !dqm[0]) r_mem[w_maddr][7:0] <= write_data[7:0];
    if (w_beat && !w_brd && wr_en && !dqm[1]) r_mem[w_maddr][15:8] <= write_data[15:8];
    r_p1_d <= r_mem[w_maddr];
  end
  // CAS latency pipeline: CL2 outputs from stage 1, CL3 from stage 2
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_p1_v <= 1'b0;
      r_p2_v <= 1'b0;
      r_p2_d <= 16'd0;
      r_rd_valid <= 1'b0;
      r_read_data <= 16'd0;
    end else begin
      r_p1_v <= w_beat & w_brd;
      r_p2_v <= r_p1_v;
      r_p2_d <= r_p1_d;
      r_rd_valid <= r_cl3 ? r_p2_v : r_p1_v;
      r_read_data <= r_cl3 ? (r_p2_v ? r_p2_d : 16'd0) : (r_p1_v ? r_p1_d : 16'd0);
    end
endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed scenario checks of the SDRAM device responder
module tb_sdram_responder;
  localparam logic [2:0] C_ACT = 3'b011, C_PRE = 3'b010, C_WR = 3'b100, C_RD = 3'b101, C_MRS = 3'b000, C_NOP = 3'b111;
  logic clk, rst, cke, cs, ras, cas, we, wr_en, rd_valid, init_done;
  logic [1:0] ba, dqm;
  logic [12:0] addr, mode_reg;
  logic [15:0] write_data, read_data;
  logic [7:0] err;
  int checks = 0, failures = 0;

  sdram_responder dut (
    .clk(clk), .rst(rst), .cke(cke), .cs(cs), .ras(ras), .cas(cas), .we(we), .ba(ba), .addr(addr),
    .dqm(dqm), .wr_en(wr_en), .write_data(write_data), .read_data(read_data), .rd_valid(rd_valid),
    .init_done(init_done), .mode_reg(mode_reg), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
    @(negedge clk);
    cs = 1'b0;
    {ras, cas, we} = c;
    ba = b;
    addr = a;
  endtask

  task automatic nop();
    cyc(C_NOP, 2'd0, 13'd0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    cs = 1'b1;
    {ras, cas, we} = C_NOP;
    wr_en = 1'b0;
    dqm = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_init(input logic [12:0] m);
    pulse_rst();
    cyc(C_PRE, 2'd0, 13'h400);
    nop();
    nop();
    cyc(C_MRS, 2'd0, m);
    nop();
    nop();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cke = 1'b1;
    cs = 1'b1;
    {ras, cas, we} = C_NOP;
    ba = 2'd0;
    addr = 13'd0;
    dqm = 2'b00;
    wr_en = 1'b0;
    write_data = 16'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (read_data !== 16'd0) begin failures++; $display("FAIL reset_read_data got=%h exp=0000", read_data); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    checks++; if (mode_reg !== 13'd0) begin failures++; $display("FAIL reset_mode_reg got=%h exp=0000", mode_reg); end
    checks++; if (err !== 8'd0) begin failures++; $display("FAIL reset_err got=%h exp=00", err); end
  endtask

  task automatic test_basic();
    do_init(13'h020);
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL basic_init_done got=%b exp=1", init_done); end
    checks++; if (mode_reg !== 13'h020) begin failures++; $display("FAIL basic_mode_reg got=%h exp=0020", mode_reg); end
    cyc(C_ACT, 2'd0, 13'd5);
    nop();
    cyc(C_WR, 2'd0, 13'd3);
    wr_en = 1'b1;
    write_data = 16'hBEEF;
    nop();
    wr_en = 1'b0;
    nop();
    cyc(C_PRE, 2'd0, 13'd0);
    nop();
    nop();
    cyc(C_ACT, 2'd0, 13'd5);
    nop();
    cyc(C_RD, 2'd0, 13'd3);
    nop();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", rd_valid); end
    nop();
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", rd_valid); end
    checks++; if (read_data !== 16'hBEEF) begin failures++; $display("FAIL basic_data got=%h exp=beef", read_data); end
    nop();
    checks++; if (rd_valid !== 1'b0 || read_data !== 16'd0) begin failures++; $display("FAIL basic_after got=%b/%h exp=0/0000", rd_valid, read_data); end
    checks++; if (err !== 8'd0) begin failures++; $display("FAIL basic_err got=%h exp=00", err); end
  endtask

  task automatic test_bl2_wrap();
    do_init(13'h031);
    checks++; if (mode_reg !== 13'h031) begin failures++; $display("FAIL bl2_mode_reg got=%h exp=0031", mode_reg); end
    cyc(C_ACT, 2'd0, 13'd5);
    nop();
    cyc(C_WR, 2'd0, 13'd0);
    wr_en = 1'b1;
    write_data = 16'h3311;
    nop();
    write_data = 16'h4444;
    nop();
    wr_en = 1'b0;
    cyc(C_WR, 2'd0, 13'd1);
    wr_en = 1'b1;
    write_data = 16'h1111;
    dqm = 2'b00;
    nop();
    write_data = 16'h2222;
    dqm = 2'b01;
    nop();
    wr_en = 1'b0;
    dqm = 2'b00;
    cyc(C_RD, 2'd0, 13'd0);
    nop();
    nop();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL bl2_cl3_early got=%b exp=0", rd_valid); end
    nop();
    checks++; if (rd_valid !== 1'b1 || read_data !== 16'h2211) begin failures++; $display("FAIL bl2_beat0 got=%b/%h exp=1/2211", rd_valid, read_data); end
    nop();
    checks++; if (rd_valid !== 1'b1 || read_data !== 16'h1111) begin failures++; $display("FAIL bl2_beat1 got=%b/%h exp=1/1111", rd_valid, read_data); end
    nop();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL bl2_end got=%b exp=0", rd_valid); end
    cyc(C_RD, 2'd0, 13'd1);
    nop();
    nop();
    nop();
    checks++; if (read_data !== 16'h1111) begin failures++; $display("FAIL wrap_beat0 got=%h exp=1111", read_data); end
    nop();
    checks++; if (read_data !== 16'h2211) begin failures++; $display("FAIL wrap_beat1 got=%h exp=2211", read_data); end
    checks++; if (err !== 8'd0) begin failures++; $display("FAIL bl2_err got=%h exp=00", err); end
  endtask

  task automatic test_rcd();
    do_init(13'h031);
    cyc(C_ACT, 2'd0, 13'd5);
    cyc(C_RD, 2'd0, 13'd1);
    nop();
    nop();
    nop();
    checks++; if (read_data !== 16'h1111 || rd_valid !== 1'b1) begin failures++; $display("FAIL rcd_beat0 got=%b/%h exp=1/1111", rd_valid, read_data); end
    nop();
    checks++; if (read_data !== 16'h2211) begin failures++; $display("FAIL rcd_beat1 got=%h exp=2211", read_data); end
    checks++; if (err !== 8'h04) begin failures++; $display("FAIL rcd_err got=%h exp=04", err); end
  endtask

  task automatic test_autopre();
    do_init(13'h020);
    cyc(C_ACT, 2'd0, 13'd5);
    nop();
    cyc(C_RD, 2'd0, 13'h403);
    nop();
    cyc(C_ACT, 2'd0, 13'd5);
    nop();
    checks++; if (err !== 8'h08) begin failures++; $display("FAIL ap_early_err got=%h exp=08", err); end
    do_init(13'h020);
    cyc(C_ACT, 2'd0, 13'd5);
    nop();
    cyc(C_RD, 2'd0, 13'h403);
    nop();
    nop();
    cyc(C_ACT, 2'd0, 13'd5);
    nop();
    checks++; if (err !== 8'h00) begin failures++; $display("FAIL ap_ok_err got=%h exp=00", err); end
    do_init(13'h020);
    cyc(C_ACT, 2'd0, 13'd5);
    nop();
    cyc(C_RD, 2'd0, 13'h403);
    nop();
    nop();
    nop();
    cyc(C_RD, 2'd0, 13'd3);
    nop();
    checks++; if (err !== 8'h01) begin failures++; $display("FAIL ap_idle_err got=%h exp=01", err); end
  endtask

  task automatic test_uninit();
    pulse_rst();
    cyc(C_ACT, 2'd0, 13'd5);
    nop();
    checks++; if (err !== 8'h20) begin failures++; $display("FAIL uninit_act_err got=%h exp=20", err); end
    cyc(C_PRE, 2'd0, 13'h400);
    nop();
    nop();
    cyc(C_MRS, 2'd0, 13'h020);
    nop();
    nop();
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL uninit_init_done got=%b exp=1", init_done); end
    cyc(C_RD, 2'd0, 13'd3);
    nop();
    nop();
    checks++; if (err !== 8'h21 || rd_valid !== 1'b0) begin failures++; $display("FAIL uninit_rd got=%h/%b exp=21/0", err, rd_valid); end
  endtask

  task automatic test_mode_err();
    do_init(13'h020);
    cyc(C_MRS, 2'd0, 13'h045);
    nop();
    checks++; if (err !== 8'h40 || mode_reg !== 13'h045) begin failures++; $display("FAIL mode_bad got=%h/%h exp=40/0045", err, mode_reg); end
    nop();
    cyc(C_ACT, 2'd0, 13'd5);
    nop();
    cyc(C_RD, 2'd0, 13'd3);
    nop();
    nop();
    checks++; if (rd_valid !== 1'b1 || read_data !== 16'hBEEF) begin failures++; $display("FAIL mode_fallback got=%b/%h exp=1/beef", rd_valid, read_data); end
    nop();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL mode_fallback_bl got=%b exp=0", rd_valid); end
    cyc(C_MRS, 2'd0, 13'h020);
    nop();
    checks++; if (err !== 8'hC0) begin failures++; $display("FAIL mode_active got=%h exp=c0", err); end
  endtask

  task automatic test_mid_reset();
    do_init(13'h023);
    cyc(C_ACT, 2'd0, 13'd5);
    nop();
    cyc(C_RD, 2'd0, 13'd0);
    nop();
    nop();
    nop();
    checks++; if (rd_valid !== 1'b1 || read_data !== 16'h1111) begin failures++; $display("FAIL mid_burst got=%b/%h exp=1/1111", rd_valid, read_data); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", rd_valid); end
    checks++; if (read_data !== 16'd0) begin failures++; $display("FAIL mid_rst_data got=%h exp=0000", read_data); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL mid_rst_init got=%b exp=0", init_done); end
    @(negedge clk);
    rst = 1'b0;
    cyc(C_RD, 2'd0, 13'd0);
    nop();
    nop();
    nop();
    checks++; if (err !== 8'h20 || rd_valid !== 1'b0) begin failures++; $display("FAIL mid_post_rd got=%h/%b exp=20/0", err, rd_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bl2_wrap();
    test_rcd();
    test_autopre();
    test_uninit();
    test_mode_err();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
